// File: rtl/sram_async_ctrl.sv
// Valid/ready front end for a 1Mx8 asynchronous SRAM: sequences CE#/OE#/WE#
// and a split tristate data bus from registered outputs, one transaction at a time.
module sram_async_ctrl #(
  parameter int unsigned ABITS   = 20,
  parameter int unsigned DBITS   = 8,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_we,
  input  logic [ABITS-1:0] i_req_addr,
  input  logic [DBITS-1:0] i_req_wdata,
  output logic             o_rsp_valid,
  output logic [DBITS-1:0] o_rsp_rdata,
  output logic [ABITS-1:0] o_sram_addr,
  output logic             o_sram_ce_n,
  output logic             o_sram_oe_n,
  output logic             o_sram_we_n,
  output logic [DBITS-1:0] o_sram_dq_out,
  output logic             o_sram_dq_oe,
  input  logic [DBITS-1:0] i_sram_dq_in
);

  localparam int unsigned MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int unsigned CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ACT,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  // The address and write data registers are the pin registers themselves, so
  // they cannot move while a strobe is active.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      o_req_ready   <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_sram_addr   <= '0;
      o_sram_ce_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
      o_sram_dq_out <= '0;
      o_sram_dq_oe  <= 1'b0;
    end else begin
      o_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          o_req_ready <= 1'b1;
          if (i_req_valid && o_req_ready) begin
            o_req_ready <= 1'b0;
            o_sram_addr <= i_req_addr;
            o_sram_ce_n <= 1'b0;
            if (i_req_we) begin
              state         <= WR_SETUP;
              o_sram_dq_out <= i_req_wdata;
              o_sram_dq_oe  <= 1'b1;
            end else begin
              state       <= RD_ACT;
              o_sram_oe_n <= 1'b0;
              wait_cnt    <= RD_LOAD;
            end
          end
        end
        RD_ACT: begin
          if (wait_cnt == '0) begin
            state       <= IDLE;
            o_rsp_rdata <= i_sram_dq_in;
            o_rsp_valid <= 1'b1;
            o_req_ready <= 1'b1;
            o_sram_ce_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        WR_SETUP: begin
          state       <= WR_PULSE;
          o_sram_we_n <= 1'b0;
          wait_cnt    <= WR_LOAD;
        end
        WR_PULSE: begin
          if (wait_cnt == '0) begin
            state       <= WR_HOLD;
            o_sram_we_n <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        WR_HOLD: begin
          state        <= IDLE;
          o_sram_ce_n  <= 1'b1;
          o_sram_dq_oe <= 1'b0;
          o_rsp_valid  <= 1'b1;
          o_req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Bench for sram_async_ctrl: three wait-state configurations run in parallel, each
// with an SRAM pin model, a cycle-level expectation of the strobes and a response scoreboard.
module tb_sram_async_ctrl;

  localparam int unsigned NCFG = 3;

  typedef struct {
    bit          we;
    logic [19:0] addr;
    logic [7:0]  data;
    int          acc_edge;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Contents of never-written SRAM locations.
  function automatic logic [7:0] init_val(input logic [19:0] a);
    return a[7:0] ^ a[19:12] ^ 8'h5A;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned R = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    localparam int unsigned W = (g == 0) ? 2 : (g == 1) ? 4 : 1;

    logic        rst = 1'b0, req_valid = 1'b0, req_we = 1'b0;
    logic        req_ready, rsp_valid, ce_n, oe_n, we_n, dq_oe;
    logic [19:0] req_addr = '0, sram_addr;
    logic [7:0]  req_wdata = '0, rsp_rdata, dq_out;
    logic [7:0]  dq_in = 8'hEE;
    int          edge_cnt = 0;
    bit          pin_chk = 1'b0, done = 1'b0;
    txn_t        q[$];
    logic [7:0]  mem[logic [19:0]];
    logic [7:0]  shadow[logic [19:0]];
    logic [19:0] last_addr = '0;
    logic [7:0]  last_rdata = '0;
    bit          prev_we_low = 1'b0;
    logic [19:0] prev_addr = '0;
    logic [7:0]  prev_dq = '0;

    sram_async_ctrl #(.ABITS(20), .DBITS(8), .RD_WAIT(R), .WR_WAIT(W)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
      .o_sram_addr(sram_addr), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
      .o_sram_dq_out(dq_out), .o_sram_dq_oe(dq_oe), .i_sram_dq_in(dq_in)
    );

    function automatic string tag(input string s);
      return $sformatf("cfg%0d(R%0d,W%0d) %s", g, R, W, s);
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // SRAM chip: stores the bus value while selected with WE# low, drives DQ while OE# low.
    always @(posedge clk) if (!ce_n && !we_n) mem[sram_addr] = dq_oe ? dq_out : 8'h00;
    always @(negedge clk)
      dq_in = (!ce_n && !oe_n) ? (mem.exists(sram_addr) ? mem[sram_addr] : init_val(sram_addr)) : 8'hEE;

    // Expected pins per cycle derived from the oldest outstanding request and its cycle index.
    always @(negedge clk) begin : mon
      logic [5:0]  exp_pins;
      logic [19:0] exp_a;
      logic [7:0]  exp_rd, exp_dq;
      bit          chk_dq, fin;
      txn_t        t;
      int          k;
      if (pin_chk) begin
        exp_pins = 6'b111001;  // {ce_n, oe_n, we_n, dq_oe, rsp_valid, req_ready}
        exp_a = last_addr; exp_rd = last_rdata; exp_dq = '0; chk_dq = 1'b0; fin = 1'b0;
        if (q.size() != 0) begin
          t = q[0];
          k = edge_cnt - t.acc_edge + 1;
          exp_a = t.addr; exp_dq = t.data; exp_pins[0] = 1'b0;
          if (!t.we) begin
            if (k <= int'(R)) exp_pins[5:4] = 2'b00;
            else begin
              exp_pins[1:0] = 2'b11; fin = 1'b1;
              exp_rd = shadow.exists(t.addr) ? shadow[t.addr] : init_val(t.addr);
            end
          end else begin
            if (k <= int'(W) + 2) begin exp_pins[5] = 1'b0; exp_pins[2] = 1'b1; chk_dq = 1'b1; end
            if (k >= 2 && k <= int'(W) + 1) exp_pins[3] = 1'b0;
            if (k >= int'(W) + 3) begin exp_pins[1:0] = 2'b11; fin = 1'b1; end
          end
        end
        check(tag("pins{ce_n,oe_n,we_n,dq_oe,rsp_valid,req_ready}"),
              32'({ce_n, oe_n, we_n, dq_oe, rsp_valid, req_ready}), 32'(exp_pins));
        check(tag("sram_addr"), 32'(sram_addr), 32'(exp_a));
        if (chk_dq) check(tag("dq_out"), 32'(dq_out), 32'(exp_dq));
        check(tag("rsp_rdata"), 32'(rsp_rdata), 32'(exp_rd));
        check(tag("oe_n_and_we_n_both_low"), 32'(!oe_n && !we_n), 32'(0));
        check(tag("dq_oe_while_oe_n_low"), 32'(dq_oe && !oe_n), 32'(0));
        if (!we_n && prev_we_low) begin
          check(tag("addr_stable_we_low"), 32'(sram_addr), 32'(prev_addr));
          check(tag("dq_stable_we_low"), 32'(dq_out), 32'(prev_dq));
        end
        prev_we_low = !we_n; prev_addr = sram_addr; prev_dq = dq_out;
        if (q.size() != 0) last_addr = t.addr;
        if (fin) begin
          if (t.we) shadow[t.addr] = t.data;
          else last_rdata = exp_rd;
          q.delete(0);
        end
      end else begin
        prev_we_low = 1'b0;
      end
    end

    // Presents a request from a falling edge until accepted; returns the accept edge number.
    task automatic issue(input bit we, input logic [19:0] a, input logic [7:0] d, output int acc_e);
      bit   rdy, acc;
      txn_t t;
      acc = 1'b0; acc_e = -1;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      for (int n = 0; n < 40; n++) begin
        rdy = req_ready;
        @(posedge clk);
        #1;
        if (rdy) begin
          acc = 1'b1;
          t.we = we; t.addr = a; t.data = d; t.acc_edge = edge_cnt;
          acc_e = edge_cnt;
          q.push_back(t);
          break;
        end
        @(negedge clk);
      end
      if (!acc) check(tag("accept_timeout"), 32'(acc), 32'(1));
      @(negedge clk);
      req_valid = 1'b0;
    endtask

    task automatic drain();
      for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
      check(tag("drain_outstanding"), 32'(q.size()), 32'(0));
      @(negedge clk);
    endtask

    initial begin : drv
      int          e1, e2;
      logic [19:0] pool[16];
      // Reset asserted between clock edges: outputs must change immediately.
      #3 rst = 1'b1;
      #1 check(tag("reset_pins"), 32'({ce_n, oe_n, we_n, dq_oe, rsp_valid, req_ready}), 32'(6'b111000));
      check(tag("reset_addr"), 32'(sram_addr), 32'(0));
      check(tag("reset_dq_out"), 32'(dq_out), 32'(0));
      check(tag("reset_rdata"), 32'(rsp_rdata), 32'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check(tag("ready_before_first_edge"), 32'(req_ready), 32'(0));
      @(posedge clk);
      #1 check(tag("ready_after_first_edge"), 32'(req_ready), 32'(1));
      pin_chk = 1'b1;
      @(negedge clk);

      issue(1'b1, 20'h12345, 8'hA5, e1);
      drain();
      issue(1'b0, 20'h12345, 8'h00, e1);
      drain();
      repeat (3) @(negedge clk);
      check(tag("rdata_held_A5"), 32'(rsp_rdata), 32'(8'hA5));

      // Back-to-back: read presented while the write is still in flight.
      issue(1'b1, 20'hFFFFF, 8'h3C, e1);
      issue(1'b0, 20'hFFFFF, 8'h00, e2);
      check(tag("b2b_accept_spacing"), 32'(e2 - e1), 32'(W + 3));
      drain();
      check(tag("b2b_read_3C"), 32'(rsp_rdata), 32'(8'h3C));

      // Reset during the write pulse drops the write and its response.
      issue(1'b1, 20'h0ABCD, 8'h77, e1);
      for (int n = 0; n < 10 && we_n; n++) @(negedge clk);
      check(tag("we_pulse_reached"), 32'(we_n), 32'(0));
      pin_chk = 1'b0;
      #2 rst = 1'b1;
      #1 check(tag("rst_mid_write_pins"), 32'({ce_n, oe_n, we_n, dq_oe, rsp_valid, req_ready}),
               32'(6'b111000));
      q.delete();
      last_addr = '0; last_rdata = '0;
      repeat (2) begin
        @(negedge clk);
        check(tag("no_rsp_during_reset"), 32'(rsp_valid), 32'(0));
      end
      #2 rst = 1'b0;
      @(posedge clk);
      #1 pin_chk = 1'b1;
      @(negedge clk);
      issue(1'b0, 20'hFFFFF, 8'h00, e1);
      drain();
      check(tag("read_after_reset_3C"), 32'(rsp_rdata), 32'(8'h3C));

      // Random traffic over a small address pool so reads hit earlier writes.
      pool[0] = 20'h00000;
      pool[1] = 20'hFFFFF;
      for (int i = 2; i < 16; i++) pool[i] = 20'($urandom);
      for (int i = 0; i < 1000; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)], 8'($urandom), e1);
      end
      drain();
      done = 1'b1;
    end
  end

  initial begin : top
    bit all_done;
    all_done = 1'b0;
    for (int n = 0; n < 60000 && !all_done; n++) begin
      @(posedge clk);
      all_done = g_cfg[0].done && g_cfg[1].done && g_cfg[2].done;
    end
    check("global_completion", 32'(all_done), 32'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
